// File: rtl/qpu_timed_event_queue_if.sv
// Write port of the timed event queue: the wbck stage pushes timestamped
// event bundles, the queue answers with i_rdy.
interface qpu_timed_event_queue_if #(
   parameter int CH = 4,
   parameter int EW = 16,
   parameter int TW = 16
);
   logic                   i_vld;
   logic                   i_rdy;
   logic [TW-1:0]          i_ts;
   logic [CH-1:0]          i_mask;
   logic [CH-1:0][1:0]     i_cond;
   logic [CH-1:0][EW-1:0]  i_dat;

   modport master (output i_vld, i_ts, i_mask, i_cond, i_dat, input i_rdy);
   modport slave  (input i_vld, i_ts, i_mask, i_cond, i_dat, output i_rdy);
endinterface

// File: rtl/qpu_timed_event_queue.sv
// Timestamped event queue: a circular buffer of event bundles released onto
// CH channels when a local timeline reaches each bundle's timestamp.
module qpu_timed_event_queue #(
   parameter int CH             = 4,
   parameter int EW             = 16,
   parameter int TW             = 16,
   parameter int DP             = 8,
   parameter bit STALL_ON_EMPTY = 1'b1,
   localparam int AW            = $clog2(DP),
   localparam int CW            = AW + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_start,
   input  logic                   i_stop,
   qpu_timed_event_queue_if.slave wr,
   input  logic [CH-1:0]          meas_one,
   input  logic [CH-1:0]          meas_zero,
   input  logic [CH-1:0]          meas_equ,
   output logic [CH-1:0]          ev_o_vld,
   output logic [CH-1:0][EW-1:0]  ev_o_dat,
   output logic [TW-1:0]          timer,
   output logic [CW-1:0]          count,
   output logic                   o_empty,
   output logic                   err_late
);

   typedef struct packed {
      logic [TW-1:0]         ts;
      logic [CH-1:0]         mask;
      logic [CH-1:0][1:0]    cond;
      logic [CH-1:0][EW-1:0] dat;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL} state_t;

   state_t                state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [CW-1:0]         count_q, count_d;
   logic [AW-1:0]         wptr_q, wptr_d;
   logic [AW-1:0]         rptr_q, rptr_d;
   logic                  err_late_q, err_late_d;
   entry_t                mem_q [DP];
   entry_t                mem_d [DP];
   logic [CH-1:0]         ev_vld_q, ev_vld_d;
   logic [CH-1:0][EW-1:0] ev_dat_q, ev_dat_d;

   entry_t        head;
   entry_t        wr_entry;
   logic [TW-1:0] diff;
   logic          full, empty, push, fire, late;
   logic [CH-1:0] cond_ok;

   assign full  = (count_q == CW'(DP));
   assign empty = (count_q == '0);
   assign push  = wr.i_vld && !full;
   assign head  = mem_q[rptr_q];

   // Late means the head lies up to half the timeline behind the timer;
   // anything further back is read as a future timestamp after wrap.
   assign diff = timer_q - head.ts;
   assign late = (diff != '0) && !diff[TW-1];
   assign fire = (state_q == S_RUN) && !empty && ((diff == '0) || late);

   assign wr_entry = '{ts: wr.i_ts, mask: wr.i_mask, cond: wr.i_cond, dat: wr.i_dat};

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      err_late_d = err_late_q | (fire & late);
      if (i_start) begin
         state_d    = S_RUN;
         timer_d    = '0;
         err_late_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_RUN: begin
               if (i_stop)                       state_d = S_IDLE;
               else if (STALL_ON_EMPTY && empty) state_d = S_STALL;
               else                              timer_d = timer_q + 1'b1;
            end
            S_STALL: begin
               if (i_stop)      state_d = S_IDLE;
               else if (!empty) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wptr_q] = wr_entry;
      wptr_d  = wptr_q + AW'(push);
      rptr_d  = rptr_q + AW'(fire);
      count_d = count_q + CW'(push) - CW'(fire);
   end

   // Per-channel gating uses the measurement inputs of the fire cycle.
   always_comb begin
      cond_ok  = '0;
      ev_vld_d = '0;
      ev_dat_d = '0;
      for (int c = 0; c < CH; c++) begin
         case (head.cond[c])
            2'b00:   cond_ok[c] = 1'b1;
            2'b01:   cond_ok[c] = meas_one[c];
            2'b10:   cond_ok[c] = meas_zero[c];
            default: cond_ok[c] = meas_equ[c];
         endcase
         ev_vld_d[c] = fire & head.mask[c] & cond_ok[c];
         if (ev_vld_d[c]) ev_dat_d[c] = head.dat[c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         err_late_q <= 1'b0;
         ev_vld_q   <= '0;
         ev_dat_q   <= '0;
         for (int i = 0; i < DP; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         err_late_q <= err_late_d;
         ev_vld_q   <= ev_vld_d;
         ev_dat_q   <= ev_dat_d;
         mem_q      <= mem_d;
      end
   end

   assign wr.i_rdy  = !full;
   assign ev_o_vld  = ev_vld_q;
   assign ev_o_dat  = ev_dat_q;
   assign timer     = timer_q;
   assign count     = count_q;
   assign o_empty   = empty;
   assign err_late  = err_late_q;

endmodule
